// File: rtl/bist_engine.sv
// Scan BIST engine: LFSR pattern source, LOAD/CAPTURE/UNLOAD scan sequencing, serial MISR compaction.
// A run lasts PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles from START to DONE; START is ignored while BUSY.
module bist_engine #(
   parameter int unsigned         LFSR_W    = 8,
   parameter logic [LFSR_W-1:0]   LFSR_POLY = 8'hB8,
   parameter logic [LFSR_W-1:0]   LFSR_SEED = 8'h01,
   parameter int unsigned         MISR_W    = 16,
   parameter logic [MISR_W-1:0]   MISR_POLY = 16'h1021,
   parameter int unsigned         CHAIN_LEN = 8,
   parameter int unsigned         PATTERNS  = 64,
   parameter logic [MISR_W-1:0]   GOLDEN    = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              SO,
   output logic              SI,
   output logic              SE,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [MISR_W-1:0] SIGNATURE,
   output logic              SIGN
);
   localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam int PW = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
   localparam logic [PW-1:0] PAT_LAST = PW'(PATTERNS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, COMPARE, FINISH} state_t;

   state_t            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [MISR_W-1:0] misr_q, misr_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]     pat_cnt_q, pat_cnt_d;
   logic              pass_q, pass_d;
   logic              start_acc, bit_last, pat_last, lfsr_adv, misr_adv;

   assign start_acc = START && ((state_q == IDLE) || (state_q == FINISH));
   assign bit_last  = (bit_cnt_q == BIT_LAST);
   assign pat_last  = (pat_cnt_q == PAT_LAST);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, FINISH: if (START) state_d = LOAD;
         LOAD:         if (bit_last) state_d = CAPTURE;
         CAPTURE:      state_d = pat_last ? UNLOAD : LOAD;
         UNLOAD:       if (bit_last) state_d = COMPARE;
         COMPARE:      state_d = FINISH;
         default:      state_d = IDLE;
      endcase
   end

   // First-pattern LOAD shifts out uninitialised chain contents, so it is not compacted.
   always_comb begin
      SE       = 1'b0;
      BUSY     = 1'b0;
      DONE     = 1'b0;
      lfsr_adv = 1'b0;
      misr_adv = 1'b0;
      case (state_q)
         LOAD: begin
            SE       = 1'b1;
            BUSY     = 1'b1;
            lfsr_adv = 1'b1;
            misr_adv = (pat_cnt_q != '0);
         end
         CAPTURE, COMPARE: BUSY = 1'b1;
         UNLOAD: begin
            SE       = 1'b1;
            BUSY     = 1'b1;
            misr_adv = 1'b1;
         end
         FINISH:  DONE = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      lfsr_d    = lfsr_q;
      misr_d    = misr_q;
      bit_cnt_d = bit_cnt_q;
      pat_cnt_d = pat_cnt_q;
      pass_d    = pass_q;
      if (start_acc) begin
         lfsr_d    = LFSR_SEED;
         misr_d    = '0;
         bit_cnt_d = '0;
         pat_cnt_d = '0;
         pass_d    = 1'b0;
      end else begin
         if (lfsr_adv) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_POLY)};
         if (misr_adv) misr_d = {misr_q[MISR_W-2:0], 1'b0}
                              ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                              ^ MISR_W'(SO);
         if (SE) bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
         if (state_q == CAPTURE) pat_cnt_d = pat_cnt_q + 1'b1;
         if (state_q == COMPARE) pass_d = (misr_q == GOLDEN);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lfsr_q    <= LFSR_SEED;
         misr_q    <= '0;
         bit_cnt_q <= '0;
         pat_cnt_q <= '0;
         pass_q    <= 1'b0;
      end else begin
         lfsr_q    <= lfsr_d;
         misr_q    <= misr_d;
         bit_cnt_q <= bit_cnt_d;
         pat_cnt_q <= pat_cnt_d;
         pass_q    <= pass_d;
      end
   end

   assign SI        = lfsr_q[0];
   assign PASS      = pass_q;
   assign SIGNATURE = misr_q;
   assign SIGN      = misr_q[MISR_W-1];
endmodule

// File: tb/tb_bist_engine.sv
// Bench for bist_engine: default-size engine against a cycle-indexed reference model,
// plus small-parameter instances for the LFSR sequence and all-ones / all-zeros compaction.
module tb_bist_engine;
   localparam int C   = 8;
   localparam int P   = 64;
   localparam int PER = C + 1;
   localparam int L   = P * PER + C + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_a, so_a, start_b, start_cd, so_cd;
   logic si_a, se_a, busy_a, done_a, pass_a, sign_a;
   logic [15:0] sig_a;
   logic si_b, se_b, busy_b, done_b, pass_b, sign_b;
   logic [15:0] sig_b;
   logic si_c, se_c, busy_c, done_c, pass_c, sign_c;
   logic [3:0] sig_c;
   logic si_d, se_d, busy_d, done_d, pass_d, sign_d;
   logic [3:0] sig_d;

   bist_engine u_a (
      .CLK(clk), .RST(rst), .START(start_a), .SO(so_a), .SI(si_a), .SE(se_a),
      .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIGNATURE(sig_a), .SIGN(sign_a));

   bist_engine #(.LFSR_W(4), .LFSR_POLY(4'h9), .LFSR_SEED(4'h1), .CHAIN_LEN(5), .PATTERNS(1)) u_b (
      .CLK(clk), .RST(rst), .START(start_b), .SO(1'b0), .SI(si_b), .SE(se_b),
      .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIGNATURE(sig_b), .SIGN(sign_b));

   bist_engine #(.MISR_W(4), .MISR_POLY(4'h3), .CHAIN_LEN(2), .PATTERNS(2), .GOLDEN(4'hF)) u_c (
      .CLK(clk), .RST(rst), .START(start_cd), .SO(so_cd), .SI(si_c), .SE(se_c),
      .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .SIGNATURE(sig_c), .SIGN(sign_c));

   bist_engine #(.MISR_W(4), .MISR_POLY(4'h3), .CHAIN_LEN(2), .PATTERNS(2), .GOLDEN(4'h0)) u_d (
      .CLK(clk), .RST(rst), .START(start_cd), .SO(so_cd), .SI(si_d), .SE(se_d),
      .BUSY(busy_d), .DONE(done_d), .PASS(pass_d), .SIGNATURE(sig_d), .SIGN(sign_d));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] lfsr8(input logic [7:0] l);
      return {l[6:0], ^(l & 8'hB8)};
   endfunction

   function automatic logic [15:0] misr16(input logic [15:0] m, input logic s);
      return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'd0, s};
   endfunction

   // cut=1 models a wire-through chain of C flops shifting on SE; otherwise SO is random.
   task automatic run_a(input bit cut, input int abort_at, input int ign_at, input int flip_at);
      logic [7:0]   ml;
      logic [15:0]  mm;
      logic [C-1:0] chain;
      logic         so;
      bit           ld, ul;
      int           p;
      @(negedge clk);
      start_a = 1'b1;
      so_a    = 1'b0;
      @(negedge clk);
      start_a = 1'b0;
      ml = 8'h01;
      mm = '0;
      chain = '0;
      for (int k = 0; k < L; k++) begin
         ld = 1'b0;
         ul = 1'b0;
         if (k < P * PER) begin
            p  = k / PER;
            ld = ((k % PER) < C);
         end else begin
            p  = P;
            ul = ((k - P * PER) < C);
         end
         chk("a_se", se_a, ld || ul);
         chk("a_busy", busy_a, 1);
         chk("a_done", done_a, 0);
         chk("a_pass", pass_a, 0);
         chk("a_si", si_a, ml[0]);
         chk("a_sig", sig_a, mm);
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            chk("rst_se", se_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_done", done_a, 0);
            chk("rst_pass", pass_a, 0);
            chk("rst_sig", sig_a, 0);
            chk("rst_sign", sign_a, 0);
            chk("rst_si", si_a, 1);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         so = cut ? chain[C-1] : 1'($urandom);
         if (k == flip_at) so = ~so;
         so_a    = so;
         start_a = (k == ign_at);
         if ((ld && p != 0) || ul) mm = misr16(mm, so);
         if (cut && (ld || ul)) chain = {chain[C-2:0], ml[0]};
         if (ld) ml = lfsr8(ml);
         @(negedge clk);
      end
      start_a = 1'b0;
      chk("a_fin_done", done_a, 1);
      chk("a_fin_busy", busy_a, 0);
      chk("a_fin_se", se_a, 0);
      chk("a_fin_sig", sig_a, mm);
      chk("a_fin_sign", sign_a, mm[15]);
      chk("a_fin_pass", pass_a, mm == 16'h0);
      chk("a_fin_si", si_a, ml[0]);
   endtask

   task automatic run_cd(input logic v);
      int         cyc;
      logic [7:0] l;
      l = 8'h01;
      repeat (4) l = lfsr8(l);
      so_cd = v;
      @(negedge clk);
      start_cd = 1'b1;
      @(negedge clk);
      start_cd = 1'b0;
      chk("cd_start_done", done_c, 0);
      chk("cd_start_pass", pass_c, 0);
      chk("cd_start_sig", sig_c, 0);
      chk("cd_start_busy", busy_c, 1);
      cyc = 0;
      while (!done_c && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("cd_len", cyc, 9);
      chk("c_sig", sig_c, v ? 4'hF : 4'h0);
      chk("c_sign", sign_c, v);
      chk("c_pass", pass_c, v);
      chk("c_busy", busy_c, 0);
      chk("c_se", se_c, 0);
      chk("c_si", si_c, l[0]);
      chk("d_sig", sig_d, v ? 4'hF : 4'h0);
      chk("d_sign", sign_d, v);
      chk("d_pass", pass_d, !v);
      chk("d_done", done_d, 1);
      chk("d_busy", busy_d, 0);
      chk("d_se", se_d, 0);
      chk("d_si", si_d, l[0]);
   endtask

   initial begin
      logic [4:0] si_exp;
      rst = 1'b1; start_a = 1'b0; so_a = 1'b0; start_b = 1'b0; start_cd = 1'b0; so_cd = 1'b0;
      #1;
      chk("init_se", se_a, 0);
      chk("init_busy", busy_a, 0);
      chk("init_done", done_a, 0);
      chk("init_pass", pass_a, 0);
      chk("init_sig", sig_a, 0);
      chk("init_sign", sign_a, 0);
      chk("init_si", si_a, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_a(1'b0, -1, -1, -1);
      run_a(1'b0, -1, P * PER + int'($urandom_range(C - 1, 0)), -1);
      run_a(1'b0, PER * int'($urandom_range(P - 1, 1)) + int'($urandom_range(C - 1, 0)), -1, -1);
      run_a(1'b0, -1, -1, -1);
      run_a(1'b1, -1, -1, -1);
      run_a(1'b1, -1, -1, P * PER + int'($urandom_range(C - 1, 0)));

      si_exp = 5'b01111;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 0; k < 12; k++) begin
         chk("b_busy", busy_b, 1);
         chk("b_done", done_b, 0);
         if (k < 5) begin
            chk("b_si", si_b, si_exp[k]);
            chk("b_se", se_b, 1);
         end
         if (k == 5) chk("b_capture_se", se_b, 0);
         @(negedge clk);
      end
      chk("b_fin_done", done_b, 1);
      chk("b_fin_sig", sig_b, 0);
      chk("b_fin_sign", sign_b, 0);
      chk("b_fin_pass", pass_b, 1);

      run_cd(1'b1);
      run_cd(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
